// File: rtl/btn_debounce_nch.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : btn_debounce_nch
// Purpose  : N-channel push-button synchroniser and debouncer with debounced
//            level, press and release pulses. Hold-to-repeat press pulses are
//            built in when the macro BTN_DEBOUNCE_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_nch #(
   parameter int NUM_BTN       = 5,
   parameter int CLK_DIV       = 100_000,
   parameter int SHIFT_DEPTH   = 8,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_btn,
   output logic [NUM_BTN-1:0] o_release
);

   localparam int                 c_div_w   = $clog2(CLK_DIV);
   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);

   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] r_level;
   logic [NUM_BTN-1:0] r_level_d;
   logic [NUM_BTN-1:0] r_btn;
   logic [NUM_BTN-1:0] r_release;
   logic [c_div_w-1:0] r_div;

   logic               w_tick;
   logic [NUM_BTN-1:0] w_set;
   logic [NUM_BTN-1:0] w_clr;
   logic [NUM_BTN-1:0] w_rise;
   logic [NUM_BTN-1:0] w_fall;
   logic [NUM_BTN-1:0] w_press;

   assign w_tick = (r_div == c_div_max);
   assign w_rise = r_level & ~r_level_d;
   assign w_fall = ~r_level & r_level_d;

   // Per-channel sample history; the level only moves when the whole window agrees.
   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
         logic [SHIFT_DEPTH-1:0] r_shift;
         logic [SHIFT_DEPTH-1:0] w_shift_nxt;
         logic                   w_unused_msb;

         assign w_shift_nxt  = {r_shift[SHIFT_DEPTH-2:0], r_sync2[i]};
         assign w_set[i]     = &w_shift_nxt;
         assign w_clr[i]     = ~|w_shift_nxt;
         assign w_unused_msb = r_shift[SHIFT_DEPTH-1];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_shift <= '0;
            end else if (w_tick) begin
               r_shift <= w_shift_nxt;
            end
         end
      end
   endgenerate

`ifdef BTN_DEBOUNCE_REPEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_cnt_w   = $clog2(c_rep_max + 1);
   localparam logic [c_cnt_w-1:0] c_delay_last  = c_cnt_w'(REPEAT_DELAY - 1);
   localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0] w_fire;
   logic [NUM_BTN-1:0] r_fire;

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_rep
         rep_state_t         r_state;
         rep_state_t         w_state_nxt;
         logic [c_cnt_w-1:0] r_cnt;
         logic [c_cnt_w-1:0] w_cnt_nxt;
         logic               w_fire_ch;
         logic               w_abort;

         // A release landing on the expiry tick must suppress that repeat.
         assign w_abort   = ~r_level[i] | (w_tick & w_clr[i]);
         assign w_fire[i] = w_fire_ch;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end else begin
               r_state <= w_state_nxt;
               r_cnt   <= w_cnt_nxt;
            end
         end

         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_fire_ch   = 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (w_rise[i]) begin
                     w_state_nxt = ST_HOLD;
                     w_cnt_nxt   = '0;
                  end
               end
               ST_HOLD: begin
                  if (w_abort) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else if (w_tick) begin
                     if (r_cnt == c_delay_last) begin
                        w_fire_ch   = 1'b1;
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                     end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                     end
                  end
               end
               ST_REPEAT: begin
                  if (w_abort) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else if (w_tick) begin
                     if (r_cnt == c_period_last) begin
                        w_fire_ch = 1'b1;
                        w_cnt_nxt = '0;
                     end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            endcase
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fire <= '0;
      end else begin
         r_fire <= w_fire;
      end
   end

   assign w_press = w_rise | r_fire;
`else
   logic w_unused_cfg;

   assign w_unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
   assign w_press      = w_rise;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_div     <= '0;
         r_level   <= '0;
         r_level_d <= '0;
         r_btn     <= '0;
         r_release <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_div     <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) begin
            r_level <= (r_level | w_set) & ~w_clr;
         end
         r_level_d <= r_level;
         r_btn     <= w_press;
         r_release <= w_fall;
      end
   end

   assign o_level   = r_level;
   assign o_btn     = r_btn;
   assign o_release = r_release;

endmodule
`default_nettype wire
